// File: rtl/pio_key_debounce.sv
// pio_key_debounce: Avalon-MM key/button PIO with a debounce per channel.
// Each key bit is synchronized and debounced in its own lane. The lane's
// accepted level ("stable") drives the data register and the edge capture
// logic. The register map follows the familiar PIO layout, with a separate
// fall-enable register next to the rise-enable register.

// One debounce lane: a two-flop synchronizer and a run-length counter.
// The counter tracks consecutive edges where sync disagrees with stable.
module pio_key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic sync,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic [CW-1:0] cnt;
  logic          mismatch;
  logic          flip;

  assign mismatch = sync ^ stable;
  // The toggle fires on the DEBOUNCE_CYCLES-th consecutive mismatching edge.
  assign flip     = mismatch && (cnt == CNT_LAST);
  assign rise     = flip & ~stable;
  assign fall     = flip &  stable;

  // Two-flop synchronizer for the asynchronous key input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // Count consecutive mismatches; any agreement discards the partial count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (!mismatch) begin
      cnt    <= '0;
    end else if (flip) begin
      cnt    <= '0;
      stable <= ~stable;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end
endmodule

// Top level: WIDTH debounce lanes plus the Avalon-MM register file.
module pio_key_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_RISE = 3'd1;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_CAP  = 3'd3;
  localparam logic [2:0] A_FALL = 3'd4;
  localparam logic [2:0] A_SYNC = 3'd5;

  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] stable_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;

  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_mux;
  logic [31:0]      unused_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      pio_key_debounce_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (in_port[gi]),
        .sync    (sync_w[gi]),
        .stable  (stable_w[gi]),
        .rise    (rise_w[gi]),
        .fall    (fall_w[gi])
      );
    end
  endgenerate

  // Only the low WIDTH bits of a write matter; the rest are dropped.
  assign unused_wdata = writedata;
  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];

  // Capture events come straight from the lanes' toggle strobes so they land
  // on the same edge as the stable change. Set beats a same-edge clear.
  assign cap_set = (rise_w & rise_en) | (fall_w & fall_en);
  assign cap_clr = (wr_en && address == A_CAP) ? wdata : '0;

  assign irq = |(edge_capture & irq_mask);

  // Writable control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_en  <= '0;
      fall_en  <= '0;
      irq_mask <= '0;
    end else if (wr_en) begin
      case (address)
        A_RISE:  rise_en  <= wdata;
        A_MASK:  irq_mask <= wdata;
        A_FALL:  fall_en  <= wdata;
        default: ;
      endcase
    end
  end

  // Edge capture: write-1-to-clear, sticky set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_capture <= '0;
    else          edge_capture <= (edge_capture & ~cap_clr) | cap_set;
  end

  // Read mux; unmapped addresses and upper bits read as zero
  always_comb begin
    rd_mux = '0;
    case (address)
      A_DATA:  rd_mux = 32'(stable_w);
      A_RISE:  rd_mux = 32'(rise_en);
      A_MASK:  rd_mux = 32'(irq_mask);
      A_CAP:   rd_mux = 32'(edge_capture);
      A_FALL:  rd_mux = 32'(fall_en);
      A_SYNC:  rd_mux = 32'(sync_w);
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, refreshed every clock regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end
endmodule
